// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one 4x4 signed Booth multiplier
//
// booth_multiplier: combinational radix-4 Booth 4x4 signed multiply.
//    i_a, i_b [3:0]  signed operands
//    o_p     [7:0]   signed product
//
// mult_share_arbiter: grants one of NUM_REQ requesters at a time, registers its
// operands for MUL_CYCLES cycles and returns the product with the owner's ID.
//    clk, rst_n       clock, asynchronous active-low reset
//    req_valid/ready  per-requester handshake (ready is one-hot, IDLE only)
//    req_a, req_b     packed 4-bit signed operands, requester i at [4i+3:4i]
//    rsp_valid/ready  response handshake
//    rsp_id           index of the requester owning the response
//    rsp_product      8-bit signed product
//    busy             high whenever the FSM is not IDLE
//    op_count         16-bit completed-response counter, present only when
//                     MULT_ARB_STATS_EN is defined

module booth_multiplier (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [7:0] o_p
);
   logic [7:0] w_a_ext;
   logic [7:0] w_pp0;
   logic [7:0] w_pp1;

   // One radix-4 Booth digit (-2..+2) applied to the sign-extended multiplicand.
   function automatic logic [7:0] booth_pp(input logic [2:0] sel, input logic [7:0] a);
      logic [7:0] pp;
      case (sel)
         3'b001, 3'b010: pp = a;
         3'b011:         pp = a << 1;
         3'b100:         pp = -(a << 1);
         3'b101, 3'b110: pp = -a;
         default:        pp = 8'h00;
      endcase
      return pp;
   endfunction

   always_comb begin
      w_a_ext = {{4{i_a[3]}}, i_a};
      w_pp0   = booth_pp({i_b[1:0], 1'b0}, w_a_ext);
      w_pp1   = booth_pp(i_b[3:1], w_a_ext);
      o_p     = w_pp0 + (w_pp1 << 2);
   end
endmodule

module mult_share_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int MUL_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [4*NUM_REQ-1:0] req_a,
   input  logic [4*NUM_REQ-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [7:0]           rsp_product,
   output logic                 busy
`ifdef MULT_ARB_STATS_EN
   ,output logic [15:0]         op_count
`endif
);
   localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);
   localparam logic [ID_W:0]   NUM_W    = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_win;
   logic [3:0]        r_op_a;
   logic [3:0]        r_op_b;
   logic [CNT_W-1:0]  r_cnt;
   logic [ID_W-1:0]   r_rsp_id;
   logic [7:0]        r_rsp_product;

   logic              w_found;
   logic [ID_W-1:0]   w_win;
   logic              w_accept;
   logic              w_capture;
   logic [7:0]        w_product;

   // Only the registered operands reach the multiplier, so the product path
   // is a true multicycle path from r_op_a/r_op_b to r_rsp_product.
   booth_multiplier u_mul (
      .i_a (r_op_a),
      .i_b (r_op_b),
      .o_p (w_product)
   );

   // Round-robin search: first asserted request at or after r_rr_ptr, with wrap.
   always_comb begin
      logic [ID_W:0] v_idx;
      w_found = 1'b0;
      w_win   = '0;
      v_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
         if (v_idx >= NUM_W) begin
            v_idx = v_idx - NUM_W;
         end
         if (!w_found && req_valid[v_idx[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = v_idx[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               req_ready   = NUM_REQ'(1) << w_win;
               w_accept    = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            // Returning to IDLE first keeps a fresh grant out of this cycle.
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr      <= '0;
         r_win         <= '0;
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_cnt         <= '0;
         r_rsp_id      <= '0;
         r_rsp_product <= '0;
      end else if (w_accept) begin
         r_op_a   <= req_a[{w_win, 2'b00} +: 4];
         r_op_b   <= req_b[{w_win, 2'b00} +: 4];
         r_win    <= w_win;
         r_cnt    <= CNT_INIT;
         r_rr_ptr <= (w_win == LAST_ID) ? '0 : w_win + 1'b1;
      end else if (w_capture) begin
         r_rsp_product <= w_product;
         r_rsp_id      <= r_win;
      end else if (r_state == ST_WAIT) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign rsp_valid   = (r_state == ST_RESP);
   assign rsp_id      = r_rsp_id;
   assign rsp_product = r_rsp_product;
   assign busy        = (r_state != ST_IDLE);

`ifdef MULT_ARB_STATS_EN
   logic [15:0] r_op_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (rsp_valid && rsp_ready) begin
         r_op_count <= r_op_count + 16'd1;
      end
   end

   assign op_count = r_op_count;
`endif
endmodule
